// File: rtl/keypad_seg_display.sv
// keypad_seg_display: 4-digit multiplexed common-anode 7-segment driver with a hex entry buffer
// fed by the keypad scanner's key_en/key_data strobe stream.
module keypad_seg_display #(
    parameter int CNT_SCAN  = 60000,
    parameter int BLANK_CYC = 600
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_en,
    input  logic [3:0]  key_data,
    input  logic        clr,
    output logic [3:0]  seg_sel,
    output logic [7:0]  seg_led,
    output logic [15:0] value,
    output logic [2:0]  count
);
    localparam logic [15:0]  LAST   = 16'(CNT_SCAN - 1);
    localparam logic [15:0]  BLANK  = 16'(BLANK_CYC);
    localparam logic [127:0] GLYPHS = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                       8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic [7:0]  led_nxt;
    // A digit is lit only once entered, except the rightmost which shows '0' on an empty buffer
    always_comb begin
        nib     = value[{idx, 2'b00} +: 4];
        led_nxt = (cnt < BLANK)                  ? 8'hFF :
                  ({1'b0, idx} < count)          ? GLYPHS[{nib, 3'b000} +: 8] :
                  (count == 3'd0 && idx == 2'd0) ? 8'hC0 : 8'hFF;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            idx     <= '0;
            seg_sel <= 4'hF;
            seg_led <= 8'hFF;
        end else begin
            cnt     <= (cnt == LAST) ? 16'd0 : cnt + 16'd1;
            idx     <= (cnt == LAST) ? idx + 2'd1 : idx;
            seg_sel <= ~(4'b0001 << idx);
            seg_led <= led_nxt;
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            value <= '0;
            count <= '0;
        end else if (key_en) begin
            if (key_data == 4'hF) begin
                value <= '0;
                count <= '0;
            end else if (key_data == 4'hE) begin
                value <= {4'h0, value[15:4]};
                count <= (count == 3'd0) ? 3'd0 : count - 3'd1;
            end else begin
                value <= {value[11:0], key_data};
                count <= (count == 3'd4) ? 3'd4 : count + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_keypad_seg_display.sv
// tb_keypad_seg_display: scoreboard bench for the keypad entry buffer and multiplexed display scan.
module tb_keypad_seg_display;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        key_en = 1'b0;
    logic [3:0]  key_data = 4'h0;
    logic        clr = 1'b0;
    logic [3:0]  seg_sel;
    logic [7:0]  seg_led;
    logic [15:0] value;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] m_val = '0;
    logic [2:0]  m_cnt = '0;
    logic [18:0] q_ent[$];
    logic [11:0] q_disp[$];
    logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    keypad_seg_display #(.CNT_SCAN(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rstn(rstn), .key_en(key_en), .key_data(key_data), .clr(clr),
        .seg_sel(seg_sel), .seg_led(seg_led), .value(value), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc = rstn ? cyc + 1 : 0;
    endtask

    // Expected display after the n-th edge since reset release
    function automatic logic [11:0] exp_disp(int n);
        int pos = (n - 1) % 8;
        int slot = ((n - 1) / 8) % 4;
        logic [3:0] sel = 4'b0001 << slot;
        logic [7:0] led;
        if (pos < 2) led = 8'hFF;
        else if (slot < int'(m_cnt)) led = glyph[m_val[4*slot +: 4]];
        else if (m_cnt == 3'd0 && slot == 0) led = 8'hC0;
        else led = 8'hFF;
        return {~sel, led};
    endfunction

    task automatic press(input logic [3:0] k, input logic c);
        logic [18:0] e;
        key_en = 1'b1;
        key_data = k;
        clr = c;
        if (c || k == 4'hF) begin
            m_val = '0;
            m_cnt = '0;
        end else if (k == 4'hE) begin
            m_val = m_val >> 4;
            m_cnt = (m_cnt == 3'd0) ? 3'd0 : m_cnt - 3'd1;
        end else begin
            m_val = {m_val[11:0], k};
            m_cnt = (m_cnt == 3'd4) ? 3'd4 : m_cnt + 3'd1;
        end
        q_ent.push_back({m_val, m_cnt});
        step();
        key_en = 1'b0;
        clr = 1'b0;
        e = q_ent.pop_front();
        checks++;
        if ({value, count} !== e) begin
            errors++;
            $display("FAIL entry key=%h clr=%0b: value=%h count=%0d, expected value=%h count=%0d",
                     k, c, value, count, e[18:3], e[2:0]);
        end
    endtask

    task automatic check_disp(input int n);
        logic [11:0] e;
        for (int i = 0; i < n; i++) begin
            q_disp.push_back(exp_disp(cyc + 1));
            step();
            e = q_disp.pop_front();
            checks++;
            if ({seg_sel, seg_led} !== e) begin
                errors++;
                $display("FAIL disp cyc=%0d: seg_sel=%b seg_led=%h, expected seg_sel=%b seg_led=%h",
                         cyc, seg_sel, seg_led, e[11:8], e[7:0]);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (seg_sel !== 4'hF || seg_led !== 8'hFF || value !== 16'h0 || count !== 3'd0) begin
            errors++;
            $display("FAIL %s: seg_sel=%b seg_led=%h value=%h count=%0d, expected 1111 FF 0000 0",
                     tag, seg_sel, seg_led, value, count);
        end
    endtask

    task automatic align(input int phase);
        while (cyc % 32 != phase) step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rstn = 1'b1;
        check_disp(32);
    endtask

    task automatic test_entry();
        press(4'h1, 1'b0);
        press(4'h2, 1'b0);
        press(4'h3, 1'b0);
        check_disp(32);
    endtask

    task automatic test_shift();
        press(4'hF, 1'b0);
        for (int k = 1; k <= 5; k++) press(4'(k), 1'b0);
        check_disp(32);
    endtask

    task automatic test_backspace();
        press(4'hE, 1'b0);
        check_disp(32);
        repeat (4) press(4'hE, 1'b0);
        check_disp(16);
    endtask

    task automatic test_clr();
        press(4'h9, 1'b0);
        press(4'h7, 1'b1);
        press(4'h5, 1'b0);
        press(4'hF, 1'b0);
        check_disp(8);
    endtask

    task automatic test_back_to_back();
        repeat (3) press(4'h6, 1'b0);
        align(4);
        press(4'hD, 1'b0);
        check_disp(36);
    endtask

    task automatic test_reset_mid();
        press(4'hF, 1'b0);
        press(4'hA, 1'b0);
        press(4'hB, 1'b0);
        align(21);
        rstn = 1'b0;
        m_val = '0;
        m_cnt = '0;
        step();
        check_reset_outputs("reset_mid");
        rstn = 1'b1;
        check_disp(16);
    endtask

    initial begin
        test_reset();
        test_entry();
        test_shift();
        test_backspace();
        test_clr();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_seg_display.md
Name: keypad_seg_display

Overview:
- Output-side counterpart to the keypad scanner: a 4-digit multiplexed 7-segment driver that scans digit selects the way the scanner scans keypad rows.
- Consumes the scanner's key_en/key_data pulse stream and holds a 4-digit hex entry buffer.
- Drives a common-anode display with active-low digit selects and segments.
- Exports the buffered value and digit count to downstream logic.

Parameters:
- CNT_SCAN, 60000: clk cycles each digit stays selected. Legal range 2..65535.
- BLANK_CYC, 600: clk cycles at the start of each digit slot with segments forced off (anti-ghosting). Legal range 0..CNT_SCAN-1.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset; synchronous, active-low
- key_en  input  1  one-cycle key strobe
- key_data  input  4  key code, valid when key_en=1
- clr  input  1  synchronous buffer clear, active-high
- seg_sel  output  4  digit select, active-low one-hot; bit0 = rightmost digit
- seg_led  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- value  output  16  entry buffer; nibble0 = rightmost digit
- count  output  3  number of entered digits, 0..4

Behaviour:
- Reset (rstn=0 at a clk edge): seg_sel=4'b1111, seg_led=8'hFF, value=0, count=0, scan counter=0, digit index=0. Reset mid-scan or mid-entry takes effect at that edge with no partial update.
- Scan counter:
  - Counts 0..CNT_SCAN-1 and wraps to 0.
  - On wrap, digit index advances 0→1→2→3→0.
- seg_sel register: 4'b1110, 4'b1101, 4'b1011, 4'b0111 for index 0..3. Exactly one bit is low at any time after reset.
- seg_led register:
  - 8'hFF while scan counter < BLANK_CYC.
  - Otherwise, if digit index < count, the decoded nibble value[4*idx+:4].
  - Otherwise, if count==0 and index 0, the glyph for '0'.
  - Otherwise 8'hFF (leading blank).
- seg_sel and seg_led are registered together from the same index and counter state, so they change on the same edge.
- dp (bit 7) is always 1 (off).
- Decode table for 0-F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- Entry, on key_en=1:
  - key_data 0..D: value <= {value[11:0], key_data}. count <= count+1, saturating at 4. At count==4 the oldest nibble is shifted out.
  - key_data E (backspace): value <= {4'h0, value[15:4]}. count <= count-1, saturating at 0.
  - key_data F: value <= 0, count <= 0.
- clr=1 clears value and count and has priority over a simultaneous key_en.
- Latency:
  - value/count update on the edge that samples key_en.
  - seg_led reflects the change one edge later if that digit is currently active and past blanking; otherwise it reflects the change at the next visit to that digit.
- Entry logic is independent of the scan; a key_en during blanking or at a digit wrap is never lost.
- key_en is level-sampled each cycle. A strobe held for N cycles is treated as N keys.

Test Plan:
- Reset, CNT_SCAN=8, BLANK_CYC=2 → seg_sel=1111 and seg_led=FF during reset. After release seg_sel cycles 1110,1101,1011,0111 with each held 8 clks. seg_led=FF for the first 2 clks of every slot. Digit 0 shows C0, digits 1-3 show FF.
- Keys 1,2,3 → value=16'h0123, count=3. Digit 0=B0, digit 1=A4, digit 2=F9, digit 3=FF.
- Keys 1,2,3,4,5 → value=16'h2345, count=4. Digit 3=A4, digit 0=92.
- From 16'h2345/4, key E → value=16'h0234, count=3, digit 3 blank. Key E four more times → value=0, count=0 (saturated), digit 0 shows C0.
- clr=1 and key_en=1 with key_data=7 in the same cycle → value=0, count=0. Key F alone → value=0, count=0.
- Enter 16'h00AB with count=2, then assert rstn=0 mid-slot (counter=5, index=2) → next edge: all outputs at reset values. After release the scan restarts at index 0 with counter 0.
